// File: rtl/dmem_access_seq_if.sv
// Request/response and data-memory bus bundle for the access sequencer.
// The sequencer is the slave on the request side and the master on the memory side.
interface dmem_access_seq_if #(
    parameter int AW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic          req_two;
    logic          req_addr_sel;
    logic          req_wb;
    logic [AW-1:0] ptr_ai;
    logic [AW-1:0] ptr_ro;
    logic [15:0]   wdata;
    logic          abort;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [7:0]    dm_wdata;
    logic [7:0]    dm_rdata;
    logic          dm_ack;
    logic [15:0]   rdata;
    logic          done;
    logic          ptr_wb_en;
    logic [AW-1:0] ptr_wb;

    modport master (
        output req_valid, req_we, req_two, req_addr_sel, req_wb,
        output ptr_ai, ptr_ro, wdata, abort, dm_rdata, dm_ack,
        input  req_ready, dm_req, dm_we, dm_addr, dm_wdata,
        input  rdata, done, ptr_wb_en, ptr_wb
    );

    modport slave (
        input  req_valid, req_we, req_two, req_addr_sel, req_wb,
        input  ptr_ai, ptr_ro, wdata, abort, dm_rdata, dm_ack,
        output req_ready, dm_req, dm_we, dm_addr, dm_wdata,
        output rdata, done, ptr_wb_en, ptr_wb
    );
endinterface

// File: rtl/dmem_access_seq.sv
// Data-memory access sequencer: one or two byte accesses per request,
// with load data return and pointer/SP write-back.
module dmem_access_seq #(
    parameter int AW = 16
) (
    input logic            clk,
    input logic            rst_n,
    dmem_access_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2,
        FIN
    } state_t;

    state_t        state;
    logic          we_q;
    logic          two_q;
    logic          wb_q;
    logic [AW-1:0] a1_q;
    logic [AW-1:0] ro_q;
    logic [15:0]   wdata_q;
    logic [7:0]    byte_q;
    logic [AW-1:0] a2;
    logic [AW-1:0] wb_val;

    // Pushes grow downward, pops upward; wrap is silent.
    always_comb begin
        a2     = we_q ? a1_q - AW'(1) : a1_q + AW'(1);
        wb_val = ro_q;
        if (two_q) begin
            wb_val = we_q ? ro_q - AW'(1) : ro_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            two_q         <= 1'b0;
            wb_q          <= 1'b0;
            a1_q          <= '0;
            ro_q          <= '0;
            wdata_q       <= '0;
            byte_q        <= '0;
            bus.req_ready <= 1'b1;
            bus.dm_req    <= 1'b0;
            bus.dm_we     <= 1'b0;
            bus.dm_addr   <= '0;
            bus.dm_wdata  <= '0;
            bus.rdata     <= '0;
            bus.done      <= 1'b0;
            bus.ptr_wb_en <= 1'b0;
            bus.ptr_wb    <= '0;
        end else begin
            bus.done      <= 1'b0;
            bus.ptr_wb_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state         <= ACC1;
                        we_q          <= bus.req_we;
                        two_q         <= bus.req_two;
                        wb_q          <= bus.req_wb;
                        ro_q          <= bus.ptr_ro;
                        wdata_q       <= bus.wdata;
                        a1_q          <= bus.req_addr_sel ? bus.ptr_ai
                                                          : bus.ptr_ro;
                        bus.req_ready <= 1'b0;
                        bus.dm_req    <= 1'b1;
                        bus.dm_we     <= bus.req_we;
                        bus.dm_addr   <= bus.req_addr_sel ? bus.ptr_ai
                                                          : bus.ptr_ro;
                        bus.dm_wdata  <= bus.wdata[7:0];
                    end
                end
                ACC1: begin
                    if (bus.abort) begin
                        state         <= IDLE;
                        bus.req_ready <= 1'b1;
                        bus.dm_req    <= 1'b0;
                        bus.dm_we     <= 1'b0;
                    end else if (bus.dm_ack) begin
                        byte_q <= bus.dm_rdata;
                        if (two_q) begin
                            state        <= ACC2;
                            bus.dm_addr  <= a2;
                            bus.dm_wdata <= wdata_q[15:8];
                        end else begin
                            state         <= FIN;
                            bus.dm_req    <= 1'b0;
                            bus.dm_we     <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.ptr_wb_en <= wb_q;
                            bus.ptr_wb    <= wb_val;
                            if (!we_q) begin
                                bus.rdata <= {8'h00, bus.dm_rdata};
                            end
                        end
                    end
                end
                ACC2: begin
                    if (bus.abort) begin
                        state         <= IDLE;
                        bus.req_ready <= 1'b1;
                        bus.dm_req    <= 1'b0;
                        bus.dm_we     <= 1'b0;
                    end else if (bus.dm_ack) begin
                        state         <= FIN;
                        bus.dm_req    <= 1'b0;
                        bus.dm_we     <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.ptr_wb_en <= wb_q;
                        bus.ptr_wb    <= wb_val;
                        if (!we_q) begin
                            bus.rdata <= {byte_q, bus.dm_rdata};
                        end
                    end
                end
                FIN: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_seq.sv
// Scoreboard bench for dmem_access_seq: memory responder with wait states,
// queue-based expectations from an address/stack reference model.
module tb_dmem_access_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_access_seq_if #(.AW(16)) ifc();

    dmem_access_seq #(.AW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    typedef struct packed {
        logic [15:0] a;
        logic        we;
        logic [7:0]  d;
    } bus_t;

    typedef struct packed {
        logic [15:0] rd;
        logic        ld;
        logic [15:0] wb;
        logic        en;
    } fin_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    bus_t bus_q[$];
    fin_t fin_q[$];
    bus_t be;
    fin_t fe;

    logic [7:0] ref_mem [65536];
    logic [7:0] bus_mem [65536];

    int   ws_fixed = 0;
    bit   manual = 1'b0;
    logic man_ack = 1'b0;
    logic auto_ack = 1'b0;
    logic [7:0] auto_rdata = 8'h00;
    bit   active = 1'b0;
    int   cnt = 0;
    int   cur_wait = 0;

    assign ifc.dm_ack   = manual ? man_ack : auto_ack;
    assign ifc.dm_rdata = auto_rdata;

    function automatic logic [7:0] init_byte(input int i);
        logic [15:0] a;
        a = i[15:0];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Memory responder; the access being acked is checked against the queue.
    always @(negedge clk) begin
        if (!rst_n || !ifc.dm_req || manual) begin
            auto_ack = 1'b0;
            active   = 1'b0;
        end else begin
            if (!active || auto_ack) begin
                active   = 1'b1;
                cnt      = 0;
                cur_wait = (ws_fixed >= 0) ? ws_fixed
                                           : int'($urandom_range(0, 3));
            end
            if (cnt >= cur_wait) begin
                auto_ack = 1'b1;
                if (ifc.dm_we) bus_mem[ifc.dm_addr] = ifc.dm_wdata;
                else auto_rdata = bus_mem[ifc.dm_addr];
                if (bus_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bus_unexpected: actual addr %h required none",
                             ifc.dm_addr);
                end else begin
                    be = bus_q.pop_front();
                    chk("bus_addr", 32'(ifc.dm_addr), 32'(be.a));
                    chk("bus_we", 32'(ifc.dm_we), 32'(be.we));
                    if (be.we) chk("bus_wdata", 32'(ifc.dm_wdata), 32'(be.d));
                end
            end else begin
                auto_ack = 1'b0;
                cnt++;
            end
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (rst_n && ifc.done) begin
            if (fin_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected: actual 1 required 0");
            end else begin
                fe = fin_q.pop_front();
                if (fe.ld) chk("rdata", 32'(ifc.rdata), 32'(fe.rd));
                chk("ptr_wb", 32'(ifc.ptr_wb), 32'(fe.wb));
                chk("ptr_wb_en", 32'(ifc.ptr_wb_en), 32'(fe.en));
            end
        end else if (rst_n && ifc.ptr_wb_en) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_en_no_done: actual 1 required 0");
        end
    end

    task automatic send(input bit we, input bit two, input bit sel,
                        input bit wb, input logic [15:0] ai,
                        input logic [15:0] ro, input logic [15:0] wd,
                        input bit model);
        logic [15:0] a1;
        logic [15:0] a2;
        fin_t f;
        int t;
        t = 0;
        while (!ifc.req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_wait", 32'(ifc.req_ready), 32'd1);
        if (model) begin
            a1 = sel ? ai : ro;
            a2 = we ? a1 - 16'd1 : a1 + 16'd1;
            bus_q.push_back('{a: a1, we: we, d: wd[7:0]});
            if (two) bus_q.push_back('{a: a2, we: we, d: wd[15:8]});
            f.ld = !we;
            f.en = wb;
            f.wb = !two ? ro : (we ? ro - 16'd1 : ro + 16'd1);
            f.rd = 16'h0000;
            if (!we) begin
                f.rd = two ? {ref_mem[a1], ref_mem[a2]}
                           : {8'h00, ref_mem[a1]};
            end else begin
                ref_mem[a1] = wd[7:0];
                if (two) ref_mem[a2] = wd[15:8];
            end
            fin_q.push_back(f);
        end
        ifc.req_valid    = 1'b1;
        ifc.req_we       = we;
        ifc.req_two      = two;
        ifc.req_addr_sel = sel;
        ifc.req_wb       = wb;
        ifc.ptr_ai       = ai;
        ifc.ptr_ro       = ro;
        ifc.wdata        = wd;
        @(negedge clk);
        ifc.req_valid = 1'b0;
    endtask

    // Entered at the negedge of T1; t tracks the cycle index after accept.
    task automatic wait_done(input int exp_lat);
        int t;
        t = 1;
        while (t < 300) begin
            @(negedge clk);
            t++;
            if (ifc.done) break;
        end
        if (!ifc.done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: actual 0 required 1");
        end else if (exp_lat > 0) begin
            chk("latency", 32'(t), 32'(exp_lat));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ai;
        logic [15:0] ro;
        int t;
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = init_byte(i);
            bus_mem[i] = init_byte(i);
        end
        ifc.req_valid    = 1'b0;
        ifc.req_we       = 1'b0;
        ifc.req_two      = 1'b0;
        ifc.req_addr_sel = 1'b0;
        ifc.req_wb       = 1'b0;
        ifc.ptr_ai       = '0;
        ifc.ptr_ro       = '0;
        ifc.wdata        = '0;
        ifc.abort        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(ifc.req_ready), 32'd1);
        chk("rst_dm_req", 32'(ifc.dm_req), 32'd0);
        chk("rst_dm_we", 32'(ifc.dm_we), 32'd0);
        chk("rst_dm_addr", 32'(ifc.dm_addr), 32'd0);
        chk("rst_dm_wdata", 32'(ifc.dm_wdata), 32'd0);
        chk("rst_rdata", 32'(ifc.rdata), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_ptr_wb", 32'(ifc.ptr_wb), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LD Rd,X+
        ws_fixed = 0;
        ref_mem[16'h0100] = 8'hA5;
        bus_mem[16'h0100] = 8'hA5;
        send(0, 0, 1, 1, 16'h0100, 16'h0101, 16'h0000, 1);
        chk("ldx_addr_t1", 32'(ifc.dm_addr), 32'h0100);
        wait_done(2);
        chk("ldx_rdata", 32'(ifc.rdata), 32'h00A5);
        chk("ldx_wb", 32'(ifc.ptr_wb), 32'h0101);

        // CALL push with one wait state per byte
        ws_fixed = 1;
        send(1, 1, 1, 1, 16'h08FF, 16'h08FE, 16'h1234, 1);
        wait_done(5);
        chk("call_wb", 32'(ifc.ptr_wb), 32'h08FD);
        chk("call_mem_lo", 32'(bus_mem[16'h08FF]), 32'h34);
        chk("call_mem_hi", 32'(bus_mem[16'h08FE]), 32'h12);

        // RET pop
        ws_fixed = 0;
        send(0, 1, 0, 1, 16'h0000, 16'h08FE, 16'h0000, 1);
        wait_done(3);
        chk("ret_rdata", 32'(ifc.rdata), 32'h1234);
        chk("ret_wb", 32'(ifc.ptr_wb), 32'h08FF);

        // Wrap cases
        send(1, 0, 0, 1, 16'h0000, 16'hFFFF, 16'h00C3, 1);
        wait_done(2);
        chk("stx_wrap_mem", 32'(bus_mem[16'hFFFF]), 32'hC3);
        send(0, 1, 0, 1, 16'h0000, 16'hFFFF, 16'h0000, 1);
        wait_done(3);
        chk("pop_wrap_wb", 32'(ifc.ptr_wb), 32'h0000);

        // Stall, ignored request, abort without ack
        manual  = 1'b1;
        man_ack = 1'b0;
        send(1, 0, 1, 1, 16'h0200, 16'h0201, 16'h0077, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", 32'(ifc.dm_req), 32'd1);
            chk("stall_addr", 32'(ifc.dm_addr), 32'h0200);
            chk("stall_wdata", 32'(ifc.dm_wdata), 32'h77);
            chk("stall_ready", 32'(ifc.req_ready), 32'd0);
            ifc.req_valid    = (i == 2);
            ifc.req_addr_sel = 1'b0;
            ifc.ptr_ro       = 16'h3333;
            @(negedge clk);
        end
        ifc.req_valid = 1'b0;
        chk("stall_addr_end", 32'(ifc.dm_addr), 32'h0200);
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        chk("abort_req", 32'(ifc.dm_req), 32'd0);
        chk("abort_ready", 32'(ifc.req_ready), 32'd1);
        chk("abort_done", 32'(ifc.done), 32'd0);
        chk("abort_wb_en", 32'(ifc.ptr_wb_en), 32'd0);

        // Abort together with the first ack of a push
        send(1, 1, 1, 1, 16'h0300, 16'h02FF, 16'hABCD, 0);
        man_ack   = 1'b1;
        ifc.abort = 1'b1;
        @(negedge clk);
        man_ack   = 1'b0;
        ifc.abort = 1'b0;
        chk("abort_ack_ready", 32'(ifc.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("abort_ack_req", 32'(ifc.dm_req), 32'd0);
            chk("abort_ack_done", 32'(ifc.done), 32'd0);
            @(negedge clk);
        end
        manual = 1'b0;

        // Reset while the second byte is pending
        ws_fixed = 2;
        send(1, 1, 1, 1, 16'h0400, 16'h03FF, 16'h5566, 1);
        t = 0;
        while (!(ifc.dm_req && ifc.dm_addr == 16'h03FF) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("reach_acc2", 32'(ifc.dm_addr), 32'h03FF);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dm_req", 32'(ifc.dm_req), 32'd0);
        chk("mid_rst_ready", 32'(ifc.req_ready), 32'd1);
        chk("mid_rst_addr", 32'(ifc.dm_addr), 32'd0);
        chk("mid_rst_ptr_wb", 32'(ifc.ptr_wb), 32'd0);
        chk("mid_rst_rdata", 32'(ifc.rdata), 32'd0);
        bus_q.delete();
        fin_q.delete();
        ref_mem[16'h03FF] = init_byte(32'h03FF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ws_fixed = 0;
        send(0, 0, 0, 1, 16'h0000, 16'h0400, 16'h0000, 1);
        wait_done(2);
        chk("post_rst_rdata", 32'(ifc.rdata), 32'h0066);

        // Randomized traffic with random wait states
        ws_fixed = -1;
        for (int n = 0; n < 60; n++) begin
            ai = 16'($urandom);
            ro = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ai = 16'hFFFE + 16'($urandom_range(0, 3));
                ro = 16'hFFFE + 16'($urandom_range(0, 3));
            end
            send(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ai, ro, 16'($urandom), 1);
            wait_done(0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("fin_q_drained", 32'(fin_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_access_seq.md
Name: dmem_access_seq

Overview:
- Data-memory access sequencer that sits directly downstream of the pointer calculation stage.
- Takes the pre-calculation pointer (ptr_ai) and the calculated pointer (ptr_ro), and issues one or two byte accesses to the data memory/IO bus with a req/ack handshake.
- Returns load data, and produces the pointer/SP write-back value for the register file or stack pointer.
- Two-byte mode covers CALL/ICALL/RCALL (push PC) and RET/RETI (pop PC).

Parameters:
AW, 16, address and pointer width; all pointer arithmetic is modulo 2^AW.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  access request from decode/execute
req_ready  out  1  high when the block can accept a request (state IDLE)
req_we  in  1  1 = store/push, 0 = load/pop
req_two  in  1  1 = two-byte return-address transfer, 0 = single byte
req_addr_sel  in  1  0 = address ptr_ro (pre-dec, displacement, LDS/STS, POP, RET); 1 = address ptr_ai (post-inc, plain X, PUSH, CALL)
req_wb  in  1  write back the updated pointer on completion
ptr_ai  in  AW  pointer pre-calculation value
ptr_ro  in  AW  pointer calculation result
wdata  in  16  store data; byte mode uses [7:0]; two-byte mode carries PC (low byte is written first)
abort  in  1  synchronous cancel (pipeline flush)
dm_req  out  1  memory request, held until acknowledged
dm_we  out  1  write strobe qualifier for dm_req
dm_addr  out  AW  byte address
dm_wdata  out  8  write byte
dm_rdata  in  8  read byte, valid in a cycle with dm_ack=1
dm_ack  in  1  memory acknowledge, 0..n wait states
rdata  out  16  load result; byte mode {8'h00,byte}; two-byte {first byte, second byte}
done  out  1  one-cycle completion pulse
ptr_wb_en  out  1  one-cycle pulse with done when req_wb=1
ptr_wb  out  AW  updated pointer/SP value

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - req_ready=1; dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0.
  - rdata=0, done=0, ptr_wb_en=0, ptr_wb=0.
  - Reset in mid-operation drops dm_req immediately and produces no done and no write-back.
- States: IDLE, ACC1, ACC2, FIN.
- IDLE:
  - req_valid=1 latches all req_*, ptr_ai, ptr_ro and wdata, then moves to ACC1.
  - dm_req rises in the next cycle.
  - req_valid while not IDLE is ignored because req_ready=0.
- First address A1 = req_addr_sel ? ptr_ai : ptr_ro.
- Direction for two-byte transfers:
  - Store: second address A2 = A1-1; write-back = ptr_ro-1.
  - Load: A2 = A1+1; write-back = ptr_ro+1.
- Single byte: write-back = ptr_ro.
- ACC1:
  - dm_req=1 and dm_addr=A1.
  - Store data: wdata[7:0].
  - Outputs stay stable until dm_ack.
  - On ack: if req_two, go to ACC2; otherwise go to FIN. A load captures dm_rdata.
- ACC2:
  - Same behaviour as ACC1, with dm_addr=A2.
  - Store data: wdata[15:8].
  - On ack, go to FIN.
- FIN (one cycle):
  - done=1 and rdata valid.
  - ptr_wb_en=req_wb and ptr_wb valid.
  - Then go to IDLE.
  - rdata and ptr_wb hold until the next completion.
- Minimum latency with zero wait states:
  - Byte: request accepted at T0, dm_req at T1 with ack, done at T2.
  - Two-byte: done at T3.
- dm_req drops in the cycle after ack; the next access starts one cycle later. Back-to-back accesses never share an ack cycle.
- Address arithmetic wraps: 16'hFFFF+1 = 16'h0000 and 16'h0000-1 = 16'hFFFF, with no flag.
- abort in ACC1/ACC2:
  - If dm_ack=0 in that cycle: drop dm_req next cycle and go to IDLE, with no done and no write-back.
  - If dm_ack=1 in the same cycle: the current byte is treated as committed, the remaining byte is skipped, and the block returns to IDLE with no done and no write-back.
- abort in IDLE or FIN has no effect. done still pulses in FIN.

Test Plan:
- Load, LD Rd,X+ (req_addr_sel=1, ptr_ai=16'h0100, ptr_ro=16'h0101, req_wb=1), zero wait states, dm_rdata=8'hA5:
  - dm_addr=16'h0100 at T1; done at T2 with rdata=16'h00A5, ptr_wb=16'h0101 and ptr_wb_en=1.
- CALL push (req_we=1, req_two=1, addr_sel=1, sp=ptr_ai=16'h08FF, ptr_ro=16'h08FE, wdata=16'h1234), one wait state per byte:
  - Writes 8'h34 to 16'h08FF, then 8'h12 to 16'h08FE.
  - done, then ptr_wb=16'h08FD.
- RET pop (addr_sel=0, ptr_ro=16'h08FE), dm_rdata 8'h12 then 8'h34:
  - Reads 16'h08FE, then 16'h08FF.
  - rdata=16'h1234 and ptr_wb=16'h08FF.
- Wrap: ST -X with ptr_ro=16'hFFFF → dm_addr=16'hFFFF. Two-byte pop with ptr_ro=16'hFFFF → A2=16'h0000 and ptr_wb=16'h0000.
- Stall and abort:
  - Hold dm_ack=0 for 5 cycles: dm_req/addr/wdata stay stable and req_ready=0; a req_valid pulse is ignored.
  - Assert abort with dm_ack=0: IDLE next cycle, with no done and no ptr_wb_en.
  - Repeat with abort and ack in the same cycle: no second access.
- Reset: drop rst_n while in ACC2 → dm_req=0 immediately and all outputs at reset values. After release, a new request completes normally.
